alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Sequential initiator for the 32-bit ripple ALU. It accepts operation requests over a valid/ready handshake and decodes each opcode into ALU control (invertA, invertB, operation). It drives the ALU operand/control ports, samples the combinational ALU outputs, and returns result plus flags over a valid/ready response channel. Multiply is done iteratively (shift-and-add, 32 steps) using only the ALU's add path. It sits between the datapath/CPU control and the ALU instance.

Parameters:
DATA_W, 32, operand/result width; fixed at 32 to match the ALU.
MUL_STEPS, DATA_W, number of multiply iterations.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 NAND, 6 SLT, 7 MUL
req_a  in  32  operand A
req_b  in  32  operand B
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  result
rsp_zero  out  1  result == 0
rsp_overflow  out  1  signed overflow
alu_src1  out  32  ALU aluSrc1
alu_src2  out  32  ALU aluSrc2
alu_invertA  out  1  ALU invertA
alu_invertB  out  1  ALU invertB
alu_operation  out  2  ALU operation: 00 AND, 01 OR, 10 ADD, 11 SLT
alu_result  in  32  ALU result (combinational)
alu_zero  in  1  ALU zero
alu_overflow  in  1  ALU overflow

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_result 0, rsp_zero 0, rsp_overflow 0. All alu_* outputs are 0. Internal acc/mcand/mplier/count are 0.
- Opcode decode to {invertA, invertB, operation}:
  - ADD: 0,0,10
  - SUB: 0,1,10
  - AND: 0,0,00
  - OR: 0,0,01
  - NOR: 1,1,00
  - NAND: 1,1,01
  - SLT: 0,1,11
  - MUL: each step 0,0,10
- States: IDLE, EXEC, MUL, DONE. Outputs are registered or state-decoded; no combinational path from req_* to rsp_*.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op/a/b.
  - op!=MUL -> EXEC.
  - op==MUL -> MUL with acc=0, mcand=a, mplier=b, count=0.
- EXEC:
  - Drive alu_src1=a, alu_src2=b and the decoded controls.
  - Register rsp_result=alu_result, rsp_zero=alu_zero, rsp_overflow=alu_overflow verbatim (SLT included).
  - Next state DONE.
- MUL, per cycle:
  - Drive alu_src1=acc, alu_src2=(mplier[0] ? mcand : 0), ADD controls.
  - acc<=alu_result; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
  - The cycle with count==MUL_STEPS-1 also loads rsp_result=final acc, rsp_zero=(final acc==0), rsp_overflow=0, then goes to DONE.
  - Result is the low 32 bits of the unsigned product, which equals the low 32 bits of the signed product.
  - No early termination: always exactly MUL_STEPS cycles.
- DONE:
  - rsp_valid=1; result and flags held stable until rsp_ready.
  - On rsp_ready -> IDLE, rsp_valid deasserts the next cycle. rsp_* data hold their last value.
- Latency, request accepted at edge T:
  - Non-MUL: rsp_valid high from T+2.
  - MUL: rsp_valid high from T+1+MUL_STEPS (T+33).
- req_ready=0 in EXEC, MUL and DONE. req_valid in those states is ignored and not queued. No back-to-back accept in the DONE->IDLE cycle: throughput is at most one op per 3 cycles.
- In IDLE and DONE, alu_* outputs are driven to 0 with controls 0,0,00.
- Reset at any time, including mid-MUL or in DONE, aborts the operation: no response is produced, and state and outputs return to reset values on the next edge.
- Wrap-around: ADD/SUB wrap modulo 2^32; overflow is reported from the ALU.

Decomposition:
- Package alu_seq_pkg holds:
  - opcode constants OP_ADD..OP_MUL (3 bits)
  - ALU operation constants ALUOP_AND/OR/ADD/SLT (2 bits)
  - state encoding IDLE/EXEC/MUL/DONE
  - DATA_W default
- No sub-module: decode is a small function or case in the package or body. The ALU stays external and is instantiated alongside in the parent/testbench.

Test Plan:
- ADD a=0x7FFFFFFF b=0x00000001 -> rsp_result 0x80000000, overflow 1, zero 0; rsp_valid exactly 2 cycles after accept.
- SUB 5-5 -> result 0, zero 1. SLT 3,7 -> result 1. SLT 7,3 -> result 0. SUB 0x80000000-1 -> 0x7FFFFFFF, overflow 1.
- NOR 0x0F0F0F0F,0x00FF00FF -> 0xF000F000. NAND 0xFFFFFFFF,0xFFFFFFFF -> 0x00000000, zero 1. AND/OR same operands -> 0x000F000F / 0x0FFF0FFF.
- MUL 0x00012345*0x00000010 -> 0x00123450 at T+33. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. MUL x*0 -> 0, zero 1, overflow 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE while pulsing req_valid with new ops -> rsp_* stable, req_ready 0, new ops never executed; response retires on rsp_ready, then req_ready=1.
- Reset asserted at MUL step 10 -> next cycle IDLE, req_ready 1, rsp_valid 0, alu_* outputs 0, no response ever emitted; a following ADD completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU initiator: opcodes, ALU control
// encodings, FSM state encoding and the opcode-to-ALU-control decode.
package alu_seq_pkg;

  localparam int DEF_DATA_W = 32;

  // Request opcodes
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  // ALU operation select
  localparam logic [1:0] ALUOP_AND = 2'b00;
  localparam logic [1:0] ALUOP_OR  = 2'b01;
  localparam logic [1:0] ALUOP_ADD = 2'b10;
  localparam logic [1:0] ALUOP_SLT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       inv_a;
    logic       inv_b;
    logic [1:0] operation;
  } alu_ctrl_t;

  // NOR and NAND come from De Morgan: invert both inputs, then AND / OR.
  // SUB and SLT invert B; the ALU uses invertB as the adder carry-in.
  function automatic alu_ctrl_t decode_op(input logic [2:0] op);
    alu_ctrl_t c;
    c = '{inv_a: 1'b0, inv_b: 1'b0, operation: ALUOP_ADD};
    case (op)
      OP_ADD:  c = '{inv_a: 1'b0, inv_b: 1'b0, operation: ALUOP_ADD};
      OP_SUB:  c = '{inv_a: 1'b0, inv_b: 1'b1, operation: ALUOP_ADD};
      OP_AND:  c = '{inv_a: 1'b0, inv_b: 1'b0, operation: ALUOP_AND};
      OP_OR:   c = '{inv_a: 1'b0, inv_b: 1'b0, operation: ALUOP_OR};
      OP_NOR:  c = '{inv_a: 1'b1, inv_b: 1'b1, operation: ALUOP_AND};
      OP_NAND: c = '{inv_a: 1'b1, inv_b: 1'b1, operation: ALUOP_OR};
      OP_SLT:  c = '{inv_a: 1'b0, inv_b: 1'b1, operation: ALUOP_SLT};
      default: c = '{inv_a: 1'b0, inv_b: 1'b0, operation: ALUOP_ADD};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequential initiator for the external 32-bit ripple ALU. Single ops take one
// ALU cycle; MUL is a fixed-length shift-and-add loop over the ALU add path.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. While
// rsp_valid is high, rsp_result/rsp_zero/rsp_overflow do not change. req_ready
// is only high in IDLE; requests presented at other times are dropped.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MUL_STEPS = DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_invertA,
  output logic              alu_invertB,
  output logic [1:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(MUL_STEPS) + 1;

  state_t            state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  count;
  alu_ctrl_t         ctrl;

  assign dbg_state     = state;
  assign alu_invertA   = ctrl.inv_a;
  assign alu_invertB   = ctrl.inv_b;
  assign alu_operation = ctrl.operation;

  // ALU drive is decoded from state and held registers only; idle states park it at zero.
  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    ctrl     = '0;
    case (state)
      EXEC: begin
        alu_src1 = a_q;
        alu_src2 = b_q;
        ctrl     = decode_op(op_q);
      end
      MUL: begin
        alu_src1 = acc;
        alu_src2 = mplier[0] ? mcand : '0;
        ctrl     = decode_op(OP_MUL);
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake outputs and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
      count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            a_q       <= req_a;
            b_q       <= req_b;
            req_ready <= 1'b0;
            if (req_op == OP_MUL) begin
              acc    <= '0;
              mcand  <= req_a;
              mplier <= req_b;
              count  <= '0;
              state  <= MUL;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          rsp_result   <= alu_result;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
          rsp_valid    <= 1'b1;
          state        <= DONE;
        end
        MUL: begin
          acc    <= alu_result;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
          // Last step: the sum on the ALU output is the final product.
          if (count == CNT_W'(MUL_STEPS - 1)) begin
            rsp_result   <= alu_result;
            rsp_zero     <= (alu_result == '0);
            rsp_overflow <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural ripple-ALU stand-in, randomized and
// directed requests, a reference model computing results from opcode meaning,
// and a per-cycle compare process against an expected queue.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_result;
  logic          rsp_zero;
  logic          rsp_overflow;
  logic [W-1:0]  alu_src1;
  logic [W-1:0]  alu_src2;
  logic          alu_invertA;
  logic          alu_invertB;
  logic [1:0]    alu_operation;
  logic [W-1:0]  alu_result;
  logic          alu_zero;
  logic          alu_overflow;
  logic [1:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // {overflow, zero, result}
  logic [W+1:0] exp_q[$];

  alu_seq_ctrl #(.DATA_W(W), .MUL_STEPS(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_invertA(alu_invertA),
    .alu_invertB(alu_invertB), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- external ALU stand-in ----------------
  logic [W-1:0] ea, eb;
  logic [W:0]   sum;
  logic         add_ovf;
  always_comb begin
    ea      = alu_invertA ? ~alu_src1 : alu_src1;
    eb      = alu_invertB ? ~alu_src2 : alu_src2;
    sum     = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, alu_invertB};
    add_ovf = (ea[W-1] == eb[W-1]) && (sum[W-1] != ea[W-1]);
    case (alu_operation)
      2'b00:   alu_result = ea & eb;
      2'b01:   alu_result = ea | eb;
      2'b10:   alu_result = sum[W-1:0];
      default: alu_result = {{(W-1){1'b0}}, sum[W-1] ^ add_ovf};
    endcase
    alu_zero     = (alu_result == '0);
    alu_overflow = alu_operation[1] ? add_ovf : 1'b0;
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, s;
    logic [63:0] p;
    logic [W-1:0] r;
    logic o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    o  = 1'b0;
    r  = '0;
    p  = '0;
    case (op)
      OP_ADD:  begin r = a + b; s = sa + sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB:  begin r = a - b; s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_SLT:  begin r = (sa < sb) ? 32'd1 : 32'd0; s = sa - sb; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      default: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; end
    endcase
    return {o, (r == '0), r};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      5: return W'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checks every cycle outside reset: response contents, idle ALU drive, handshake exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_valid_excl", 64'(req_ready & rsp_valid), 64'd0);
      if (req_ready || rsp_valid)
        check("alu_parked", 64'(|{alu_src1, alu_src2, alu_invertA, alu_invertB, alu_operation}), 64'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          check("rsp_result",   64'(rsp_result),   64'(exp_q[0][W-1:0]));
          check("rsp_zero",     64'(rsp_zero),     64'(exp_q[0][W]));
          check("rsp_overflow", 64'(rsp_overflow), 64'(exp_q[0][W+1]));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output bit ok, output int acc_cyc);
    int n;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    ok = req_ready;
    if (!ok) check("accept_timeout", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit pulse);
    bit ok;
    int acc_cyc, n;
    issue(op, a, b, ok, acc_cyc);
    if (!ok) return;
    exp_q.push_back(ref_op(op, a, b));
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      check("rsp_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    check("latency", 64'(cyc - acc_cyc + 1), (op == OP_MUL) ? 64'd33 : 64'd2);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (pulse) begin
        req_valid = (i % 2 == 0);
        req_op    = 3'($urandom_range(0, 7));
        req_a     = $urandom;
        req_b     = $urandom;
      end
      @(negedge clk);
      check("req_ready_busy", 64'(req_ready), 64'd0);
      check("rsp_valid_held", 64'(rsp_valid), 64'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("req_ready_back", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int acc_cyc;

    // Model pins: hand-computed expectations
    check("pin_add_ovf",  64'(ref_op(OP_ADD,  32'h7FFFFFFF, 32'h1)), 64'h2_8000_0000);
    check("pin_sub_zero", 64'(ref_op(OP_SUB,  32'd5, 32'd5)),        64'h1_0000_0000);
    check("pin_slt_lt",   64'(ref_op(OP_SLT,  32'd3, 32'd7)),        64'h0_0000_0001);
    check("pin_slt_ge",   64'(ref_op(OP_SLT,  32'd7, 32'd3)),        64'h1_0000_0000);
    check("pin_sub_ovf",  64'(ref_op(OP_SUB,  32'h80000000, 32'h1)), 64'h2_7FFF_FFFF);
    check("pin_nor",      64'(ref_op(OP_NOR,  32'h0F0F0F0F, 32'h00FF00FF)), 64'h0_F000_F000);
    check("pin_nand",     64'(ref_op(OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h1_0000_0000);
    check("pin_and",      64'(ref_op(OP_AND,  32'h0F0F0F0F, 32'h00FF00FF)), 64'h0_000F_000F);
    check("pin_or",       64'(ref_op(OP_OR,   32'h0F0F0F0F, 32'h00FF00FF)), 64'h0_0FFF_0FFF);
    check("pin_mul",      64'(ref_op(OP_MUL,  32'h00012345, 32'h10)), 64'h0_0012_3450);
    check("pin_mul_m1",   64'(ref_op(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h0_0000_0001);
    check("pin_mul_zero", 64'(ref_op(OP_MUL,  32'hDEADBEEF, 32'h0)), 64'h1_0000_0000);

    // Reset and reset values
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready",  64'(req_ready),    64'd1);
    check("rst_rsp_valid",  64'(rsp_valid),    64'd0);
    check("rst_rsp_result", 64'(rsp_result),   64'd0);
    check("rst_rsp_zero",   64'(rsp_zero),     64'd0);
    check("rst_rsp_ovf",    64'(rsp_overflow), 64'd0);
    check("rst_alu_src",    64'(alu_src1 | alu_src2), 64'd0);
    check("rst_alu_ctrl",   64'({alu_invertA, alu_invertB, alu_operation}), 64'd0);
    @(posedge clk); #1;

    // Directed test-plan vectors
    run_op(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 0, 0);
    run_op(OP_SUB,  32'd5, 32'd5, 1, 0);
    run_op(OP_SLT,  32'd3, 32'd7, 0, 0);
    run_op(OP_SLT,  32'd7, 32'd3, 0, 0);
    run_op(OP_SUB,  32'h80000000, 32'h1, 0, 0);
    run_op(OP_NOR,  32'h0F0F0F0F, 32'h00FF00FF, 0, 0);
    run_op(OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(OP_AND,  32'h0F0F0F0F, 32'h00FF00FF, 0, 0);
    run_op(OP_OR,   32'h0F0F0F0F, 32'h00FF00FF, 0, 0);
    run_op(OP_MUL,  32'h00012345, 32'h00000010, 0, 0);
    run_op(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(OP_MUL,  32'h12345678, 32'h00000000, 0, 0);

    // Backpressure with dropped requests during DONE
    run_op(OP_ADD, 32'd100, 32'd23, 5, 1);
    run_op(OP_MUL, 32'd77, 32'd3, 5, 1);

    // Reset during MUL step 10: no response may appear afterwards
    issue(OP_MUL, 32'hCAFEF00D, 32'h0BADBEEF, ok, acc_cyc);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_alu",       64'(|{alu_src1, alu_src2, alu_invertA, alu_invertB, alu_operation}), 64'd0);
    check("abort_rsp_data",  64'({rsp_result, rsp_zero, rsp_overflow}), 64'd0);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;
    run_op(OP_ADD, 32'd1, 32'd2, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
